pipeline_memd_stage8: RTL and testbench
=======================================

# pipeline_memd_stage8

Memory-data receive stage of the 8-stage pipeline. It sits directly downstream of the memory-prepare stage and upstream of write-back. It accepts load data from the system bus (zero wait) or DRAM (variable latency, valid-qualified). It aligns and sign- or zero-extends the data, requests a pipeline stall while a DRAM access is outstanding, and registers the result for write-back. A watchdog terminates DRAM accesses that never complete.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum wait-state cycles for a DRAM access before forced completion (≥2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  global hold from the hazard unit.
- is_dram_MEMP  in  1  the access in this stage targets DRAM.
- pc_MEMP, alu_result_MEMP  in  64 each  PC and ALU result / access address.
- rf_wr_sel_MEMP  in  2  write-back source select.
- rf_wr_en_MEMP  in  1  register write enable.
- rd_MEMP  in  5  destination register.
- sys_bus_rd_ctrl, dram_rd_ctrl  in  3 each  registered read controls issued by the memory-prepare stage.
- dram_wr_ctrl  in  3  registered DRAM write control.
- sys_bus_dout  in  64  bus read doubleword, valid in the same cycle.
- dram_dout  in  64  DRAM read doubleword, valid when dram_valid=1.
- dram_valid  in  1  DRAM read-data or write-acknowledge strobe.
- stall_req_MEMD  out  1  combinational request to freeze upstream stages.
- pc_MEMD, alu_result_MEMD, dm_dout_MEMD  out  64 each  registered to write-back.
- rf_wr_sel_MEMD  out  2; rf_wr_en_MEMD  out  1; rd_MEMD  out  5  registered to write-back.
- mem_err_MEMD  out  1  registered one-cycle pulse on timeout.

## Operation
- Read-control encoding: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 110 LWU, 111 LD.
- rd_ctrl is dram_rd_ctrl when is_dram_MEMP=1, else sys_bus_rd_ctrl. Source data selection follows the same rule.
- Lane alignment: the selected 64-bit doubleword is shifted right by alu_result_MEMP[2:0]×8.
  - Result is the low 8/16/32/64 bits.
  - Sign-extended for LB/LH/LW, zero-extended for LBU/LHU/LWU.
  - Misaligned halfword/word/doubleword accesses are not detected; upper bits shifted in are 0.
- dram_access = is_dram_MEMP & (dram_rd_ctrl≠0 | dram_wr_ctrl≠0).
- FSM states:
  - IDLE: if dram_access & ~dram_valid, go to WAIT and clear cnt. Otherwise stay in IDLE.
  - WAIT: cnt increments each cycle.
    - On dram_valid, go to IDLE (normal completion).
    - On cnt==TIMEOUT_CYCLES-1 with no dram_valid, go to IDLE (forced completion).
- stall_req_MEMD = (IDLE & dram_access & ~dram_valid) | (WAIT & ~dram_valid & cnt≠TIMEOUT_CYCLES-1).
- Output register update, in priority order:
  1. stall_req_MEMD=1: load a bubble (rf_wr_en_MEMD=0, rd_MEMD=0, mem_err_MEMD=0). Other outputs keep their values.
  2. stall=1: hold all outputs. mem_err_MEMD is forced to 0.
  3. Otherwise: capture pc, rf_wr_sel, rf_wr_en, alu_result and rd from the _MEMP inputs. Capture dm_dout_MEMD from the extended data, or 0 when rd_ctrl=000.
     - mem_err_MEMD = 1 only on a forced completion.
     - On forced completion, dm_dout_MEMD = 0 and rf_wr_en is passed through unchanged.
- System bus accesses and non-memory instructions never raise stall_req_MEMD.
- A DRAM write with no read still waits for dram_valid as its write acknowledge.
- dram_valid received in IDLE with no dram_access is ignored.

## Timing
- Reset (asynchronous):
  - FSM = IDLE, cnt = 0.
  - All outputs = 0, stall_req_MEMD = 0.
  - Reset during WAIT abandons the access; a late dram_valid afterwards is ignored.
- Latency:
  - Bus access or non-memory instruction: 1 cycle; the result is visible the cycle after the instruction enters MEMD.
  - DRAM access: N+1 cycles when dram_valid arrives N cycles after entry (N=0 completes with no stall). During those N cycles stall_req_MEMD=1 and the bubble is emitted.
- Timeout: stall_req_MEMD is high for exactly TIMEOUT_CYCLES cycles. Completion occurs on the next edge.
- Back-to-back DRAM accesses: IDLE is re-entered on the completion edge, so the next access can be evaluated in the following cycle with no dead cycle.
- stall_req_MEMD depends only on FSM state, cnt, the _MEMP/ctrl inputs and dram_valid. It has no path from stall.

## Test plan
- LB from the system bus: alu_result=0x1003, sys_bus_rd_ctrl=001, sys_bus_dout=0x00000000_80000000 -> next cycle dm_dout_MEMD=0xFFFFFFFF_FFFFFF80, no stall. Repeat with LBU -> 0x80.
- DRAM LW: addr=0x8000_0004, dram_valid 3 cycles after entry with dout=0xDEADBEEF_12345678 -> stall_req high 3 cycles, 3 bubbles, then dm_dout_MEMD=0xFFFFFFFF_DEADBEEF.
- Timeout with TIMEOUT_CYCLES=4 and dram_valid never asserted -> stall 4 cycles, then mem_err_MEMD=1 for one cycle and dm_dout_MEMD=0.
- External stall=1 for 2 cycles after completing an ALU instruction (rd=5) -> outputs hold; mem_err stays 0.
- Reset asserted mid-WAIT, then dram_valid pulsed -> all outputs 0, FSM IDLE, the pulse is ignored.
- Two consecutive DRAM LD accesses, each with a 1-cycle latency -> exactly 1 bubble each, with correct data and rd for each.

Source files
------------

// File: rtl/pipeline_memd_stage8.sv
// Memory-data receive stage: selects bus or DRAM load data, aligns and extends it, stalls while
// a DRAM access is outstanding and registers the result for write-back.
module pipeline_memd_stage8 #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_dram_MEMP,
  input  logic [63:0] pc_MEMP,
  input  logic [63:0] alu_result_MEMP,
  input  logic [1:0]  rf_wr_sel_MEMP,
  input  logic        rf_wr_en_MEMP,
  input  logic [4:0]  rd_MEMP,
  input  logic [2:0]  sys_bus_rd_ctrl,
  input  logic [2:0]  dram_rd_ctrl,
  input  logic [2:0]  dram_wr_ctrl,
  input  logic [63:0] sys_bus_dout,
  input  logic [63:0] dram_dout,
  input  logic        dram_valid,
  output logic        stall_req_MEMD,
  output logic [63:0] pc_MEMD,
  output logic [63:0] alu_result_MEMD,
  output logic [63:0] dm_dout_MEMD,
  output logic [1:0]  rf_wr_sel_MEMD,
  output logic        rf_wr_en_MEMD,
  output logic [4:0]  rd_MEMD,
  output logic        mem_err_MEMD
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;

  logic [63:0] r_pc, r_alu_result, r_dm_dout;
  logic [1:0]  r_rf_wr_sel;
  logic        r_rf_wr_en, r_mem_err;
  logic [4:0]  r_rd;

  logic [2:0]  w_rd_ctrl;
  logic [63:0] w_src, w_shifted, w_ext;
  logic        w_access, w_forced, w_stall_req;

  assign w_rd_ctrl = is_dram_MEMP ? dram_rd_ctrl : sys_bus_rd_ctrl;
  assign w_src     = is_dram_MEMP ? dram_dout : sys_bus_dout;
  assign w_shifted = w_src >> {alu_result_MEMP[2:0], 3'b000};
  assign w_access  = is_dram_MEMP & ((dram_rd_ctrl != 3'b000) | (dram_wr_ctrl != 3'b000));
  assign w_forced  = (r_state == StWait) & ~dram_valid & (r_cnt == CntLast);

  always_comb begin
    w_ext = '0;
    unique case (w_rd_ctrl)
      3'b001:  w_ext = {{56{w_shifted[7]}}, w_shifted[7:0]};
      3'b010:  w_ext = {56'd0, w_shifted[7:0]};
      3'b011:  w_ext = {{48{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ext = {48'd0, w_shifted[15:0]};
      3'b101:  w_ext = {{32{w_shifted[31]}}, w_shifted[31:0]};
      3'b110:  w_ext = {32'd0, w_shifted[31:0]};
      3'b111:  w_ext = w_shifted;
      default: w_ext = '0;
    endcase
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_stall_req = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_access & ~dram_valid) begin
          w_state_d   = StWait;
          w_cnt_d     = '0;
          w_stall_req = 1'b1;
        end
      end
      StWait: begin
        w_cnt_d     = r_cnt + 1'b1;
        w_stall_req = ~dram_valid & (r_cnt != CntLast);
        if (dram_valid | (r_cnt == CntLast)) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Bubble beats external hold; a held cycle never re-reports an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= '0;
      r_alu_result <= '0;
      r_dm_dout    <= '0;
      r_rf_wr_sel  <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rd         <= '0;
      r_mem_err    <= 1'b0;
    end else if (w_stall_req) begin
      r_rf_wr_en <= 1'b0;
      r_rd       <= '0;
      r_mem_err  <= 1'b0;
    end else if (stall) begin
      r_mem_err <= 1'b0;
    end else begin
      r_pc         <= pc_MEMP;
      r_alu_result <= alu_result_MEMP;
      r_rf_wr_sel  <= rf_wr_sel_MEMP;
      r_rf_wr_en   <= rf_wr_en_MEMP;
      r_rd         <= rd_MEMP;
      r_dm_dout    <= w_forced ? 64'd0 : w_ext;
      r_mem_err    <= w_forced;
    end
  end

  assign stall_req_MEMD  = w_stall_req;
  assign pc_MEMD         = r_pc;
  assign alu_result_MEMD = r_alu_result;
  assign dm_dout_MEMD    = r_dm_dout;
  assign rf_wr_sel_MEMD  = r_rf_wr_sel;
  assign rf_wr_en_MEMD   = r_rf_wr_en;
  assign rd_MEMD         = r_rd;
  assign mem_err_MEMD    = r_mem_err;

endmodule

// File: tb/tb_pipeline_memd_stage8.sv
// Directed bench for pipeline_memd_stage8 with a short DRAM timeout.
module tb_pipeline_memd_stage8;

  logic        clk, reset, stall, is_dram_MEMP, rf_wr_en_MEMP, dram_valid;
  logic [63:0] pc_MEMP, alu_result_MEMP, sys_bus_dout, dram_dout;
  logic [1:0]  rf_wr_sel_MEMP;
  logic [4:0]  rd_MEMP;
  logic [2:0]  sys_bus_rd_ctrl, dram_rd_ctrl, dram_wr_ctrl;
  logic        stall_req_MEMD, rf_wr_en_MEMD, mem_err_MEMD;
  logic [63:0] pc_MEMD, alu_result_MEMD, dm_dout_MEMD;
  logic [1:0]  rf_wr_sel_MEMD;
  logic [4:0]  rd_MEMD;

  int n_vec = 0;
  int n_err = 0;

  pipeline_memd_stage8 #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .is_dram_MEMP    (is_dram_MEMP),
    .pc_MEMP         (pc_MEMP),
    .alu_result_MEMP (alu_result_MEMP),
    .rf_wr_sel_MEMP  (rf_wr_sel_MEMP),
    .rf_wr_en_MEMP   (rf_wr_en_MEMP),
    .rd_MEMP         (rd_MEMP),
    .sys_bus_rd_ctrl (sys_bus_rd_ctrl),
    .dram_rd_ctrl    (dram_rd_ctrl),
    .dram_wr_ctrl    (dram_wr_ctrl),
    .sys_bus_dout    (sys_bus_dout),
    .dram_dout       (dram_dout),
    .dram_valid      (dram_valid),
    .stall_req_MEMD  (stall_req_MEMD),
    .pc_MEMD         (pc_MEMD),
    .alu_result_MEMD (alu_result_MEMD),
    .dm_dout_MEMD    (dm_dout_MEMD),
    .rf_wr_sel_MEMD  (rf_wr_sel_MEMD),
    .rf_wr_en_MEMD   (rf_wr_en_MEMD),
    .rd_MEMD         (rd_MEMD),
    .mem_err_MEMD    (mem_err_MEMD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 0; is_dram_MEMP = 0; rf_wr_en_MEMP = 0; dram_valid = 0;
    pc_MEMP = '0; alu_result_MEMP = '0; sys_bus_dout = '0; dram_dout = '0;
    rf_wr_sel_MEMP = '0; rd_MEMP = '0;
    sys_bus_rd_ctrl = '0; dram_rd_ctrl = '0; dram_wr_ctrl = '0;
  endtask

  task automatic drive_instr(input logic dram, input logic [2:0] rctl, input logic [63:0] addr,
                             input logic [4:0] rd, input logic [63:0] pc);
    is_dram_MEMP = dram; alu_result_MEMP = addr; rd_MEMP = rd; pc_MEMP = pc;
    rf_wr_en_MEMP = 1'b1; rf_wr_sel_MEMP = 2'd1;
    sys_bus_rd_ctrl = dram ? 3'b000 : rctl;
    dram_rd_ctrl    = dram ? rctl : 3'b000;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".pc"}, pc_MEMD, 0);
    check_eq({tag, ".alu"}, alu_result_MEMD, 0);
    check_eq({tag, ".dm"}, dm_dout_MEMD, 0);
    check_eq({tag, ".misc"}, {rf_wr_sel_MEMD, rf_wr_en_MEMD, rd_MEMD, mem_err_MEMD,
                              stall_req_MEMD}, 0);
  endtask

  // Bus load vectors: address, control, bus doubleword, expected extended result.
  logic [63:0] bv_addr [6] = '{64'h1003, 64'h1003, 64'h1002, 64'h1004, 64'h1001, 64'h1000};
  logic [2:0]  bv_ctl  [6] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b000};
  logic [63:0] bv_dout [6] = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
                               64'h0000_0000_8001_0000, 64'h8765_4321_0000_0000,
                               64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] bv_exp  [6] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080,
                               64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_8765_4321,
                               64'h0011_2233_4455_6677, 64'h0};

  initial begin
    clear_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // System-bus loads: one-cycle latency, never a stall.
    for (int i = 0; i < 6; i++) begin
      drive_instr(1'b0, bv_ctl[i], bv_addr[i], 5'(i + 1), 64'h100 + 64'(i * 4));
      sys_bus_dout = bv_dout[i];
      #1;
      check_eq($sformatf("bus%0d.stall", i), stall_req_MEMD, 0);
      step();
      check_eq($sformatf("bus%0d.dm", i), dm_dout_MEMD, bv_exp[i]);
      check_eq($sformatf("bus%0d.rd", i), rd_MEMD, 64'(i + 1));
    end
    check_eq("bus.pc", pc_MEMD, 64'h114);

    // DRAM LW, data three cycles after entry.
    drive_instr(1'b1, 3'b101, 64'h8000_0004, 5'd7, 64'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("lw.stall%0d", i), stall_req_MEMD, 1);
      step();
      check_eq($sformatf("lw.bubble%0d", i), {rf_wr_en_MEMD, rd_MEMD}, 0);
    end
    dram_valid = 1'b1; dram_dout = 64'hDEAD_BEEF_1234_5678;
    #1;
    check_eq("lw.stall_done", stall_req_MEMD, 0);
    step();
    check_eq("lw.dm", dm_dout_MEMD, 64'hFFFF_FFFF_DEAD_BEEF);
    check_eq("lw.rd", {rf_wr_en_MEMD, rd_MEMD}, {1'b1, 5'd7});
    check_eq("lw.err", mem_err_MEMD, 0);
    clear_in();

    // Timeout: no dram_valid ever.
    drive_instr(1'b1, 3'b111, 64'h0, 5'd9, 64'h300);
    dram_dout = 64'h5555_5555_5555_5555;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("to.stall%0d", i), stall_req_MEMD, 1);
      step();
      check_eq($sformatf("to.err_low%0d", i), mem_err_MEMD, 0);
    end
    #1;
    check_eq("to.stall_end", stall_req_MEMD, 0);
    step();
    check_eq("to.err", mem_err_MEMD, 1);
    check_eq("to.dm", dm_dout_MEMD, 0);
    check_eq("to.rd", {rf_wr_en_MEMD, rd_MEMD}, {1'b1, 5'd9});

    // ALU instruction, then external stall for two cycles.
    clear_in();
    drive_instr(1'b0, 3'b000, 64'h55, 5'd5, 64'h400);
    step();
    check_eq("alu.err_cleared", mem_err_MEMD, 0);
    check_eq("alu.rd", rd_MEMD, 5);
    check_eq("alu.res", alu_result_MEMD, 64'h55);
    drive_instr(1'b0, 3'b000, 64'h66, 5'd6, 64'h404);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq($sformatf("hold%0d.stall_req", i), stall_req_MEMD, 0);
      step();
      check_eq($sformatf("hold%0d.rd", i), rd_MEMD, 5);
      check_eq($sformatf("hold%0d.alu", i), alu_result_MEMD, 64'h55);
      check_eq($sformatf("hold%0d.pc", i), pc_MEMD, 64'h400);
      check_eq($sformatf("hold%0d.err", i), mem_err_MEMD, 0);
    end
    stall = 1'b0;
    step();
    check_eq("hold.release", rd_MEMD, 6);

    // Reset in the middle of a DRAM wait, then a stray dram_valid.
    drive_instr(1'b1, 3'b111, 64'h8, 5'd12, 64'h500);
    step();
    step();
    #1;
    check_eq("rst.waiting", stall_req_MEMD, 1);
    reset = 1'b1;
    #1;
    clear_in();
    #1;
    check_all_zero("rst.async");
    step();
    reset = 1'b0;
    dram_valid = 1'b1; dram_dout = 64'hABCD_ABCD_ABCD_ABCD;
    step();
    check_all_zero("rst.late_valid");
    dram_valid = 1'b0;
    #1;
    check_eq("rst.idle", stall_req_MEMD, 0);

    // Back-to-back LDs, one-cycle latency each.
    for (int i = 0; i < 2; i++) begin
      drive_instr(1'b1, 3'b111, 64'h0, 5'(10 + i), 64'h600 + 64'(i * 4));
      dram_valid = 1'b0;
      #1;
      check_eq($sformatf("b2b%0d.stall", i), stall_req_MEMD, 1);
      step();
      check_eq($sformatf("b2b%0d.bubble", i), {rf_wr_en_MEMD, rd_MEMD}, 0);
      dram_valid = 1'b1;
      dram_dout = (i == 0) ? 64'h0123_4567_89AB_CDEF : 64'hFEDC_BA98_7654_3210;
      #1;
      check_eq($sformatf("b2b%0d.go", i), stall_req_MEMD, 0);
      step();
      check_eq($sformatf("b2b%0d.dm", i), dm_dout_MEMD,
               (i == 0) ? 64'h0123_4567_89AB_CDEF : 64'hFEDC_BA98_7654_3210);
      check_eq($sformatf("b2b%0d.rd", i), rd_MEMD, 64'(10 + i));
    end

    // DRAM data in the entry cycle completes without a stall.
    drive_instr(1'b1, 3'b011, 64'h6, 5'd14, 64'h700);
    dram_valid = 1'b1; dram_dout = 64'hF00F_0000_0000_0000;
    #1;
    check_eq("n0.stall", stall_req_MEMD, 0);
    step();
    check_eq("n0.dm", dm_dout_MEMD, 64'hFFFF_FFFF_FFFF_F00F);
    clear_in();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
